// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer
//   Data-memory responder for the single-cycle core. Stores are posted into a
//   small in-order buffer. The buffer drains one entry per cycle into a
//   word-addressed RAM whenever no load is in progress. Loads forward from the
//   youngest buffered store to the same word, or fall back to the RAM.
//
// Ports
//   clk, reset   rising-edge clock, synchronous active-high reset
//   memwrite     store request this cycle
//   memread      load in progress this cycle (blocks draining)
//   dataadr      byte address; word index = dataadr[AW+1:2]
//   writedata    store data
//   readdata     combinational load data (forwarded or from RAM)
//   stall        store refused this cycle because the buffer is full
//   pending      number of valid buffer entries
//   drain_wr     registered pulse: an entry reached RAM on the last edge
//   drain_adr    registered word index of the last drained entry
module dmem_store_buffer #(
  parameter int AW    = 6,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memwrite,
  input  logic          memread,
  input  logic [31:0]   dataadr,
  input  logic [31:0]   writedata,
  output logic [31:0]   readdata,
  output logic          stall,
  output logic [CW-1:0] pending,
  output logic          drain_wr,
  output logic [AW-1:0] drain_adr
);

  localparam int PW = $clog2(DEPTH);

  logic [31:0]   ram  [2**AW];
  logic [AW-1:0] badr [DEPTH];
  logic [31:0]   bdat [DEPTH];

  logic [PW-1:0] head, tail, p;
  logic [CW-1:0] count;
  logic [AW-1:0] idx;
  logic          full, empty, enq, drn;
  logic          unused_adr;

  // Word access only; byte-offset bits and bits above the RAM aliasing range
  // carry no meaning here.
  assign idx        = dataadr[AW+1:2];
  assign unused_adr = ^{dataadr[31:AW+2], dataadr[1:0]};

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A full buffer refuses the store even if it drains on the same edge.
  assign enq     = !reset && memwrite && !full;
  assign drn     = !reset && !empty && !memread;
  assign stall   = !reset && memwrite && full;
  assign pending = count;

  always_ff @(posedge clk) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      drain_wr  <= 1'b0;
      drain_adr <= '0;
    end else begin
      if (enq) tail <= tail + PW'(1);
      if (drn) begin
        head      <= head + PW'(1);
        drain_adr <= badr[head];
      end
      drain_wr <= drn;
      case ({enq, drn})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Buffer storage and RAM have no reset: contents are qualified by the
  // pointers/count, and the RAM must survive a reset.
  always_ff @(posedge clk) begin
    if (enq) begin
      badr[tail] <= idx;
      bdat[tail] <= writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (drn) ram[badr[head]] <= bdat[head];
  end

  // Walk entries oldest to youngest starting at head; a later match overrides
  // an earlier one, so the youngest matching store wins across wrap-around.
  always_comb begin
    readdata = ram[idx];
    p        = '0;
    for (int k = 0; k < DEPTH; k++) begin
      p = head + PW'(k);
      if ((CW'(k) < count) && (badr[p] == idx)) readdata = bdat[p];
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb_dmem_store_buffer
//   Directed bench for dmem_store_buffer. Accepted stores are pushed onto a
//   scoreboard queue and popped when the buffer is expected to drain one;
//   a shadow RAM tracks which words hold known values for load checks.
module tb_dmem_store_buffer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] data;
  } entry_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwrite = 1'b0;
  logic        memread = 1'b0;
  logic [31:0] dataadr = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        stall;
  logic [2:0]  pending;
  logic        drain_wr;
  logic [5:0]  drain_adr;

  entry_t      sbq[$];
  logic [31:0] mmem   [64];
  bit          mknown [64];
  logic        expDrain;
  logic [5:0]  expDrainAdr;
  int          vectors = 0;
  int          miscompares = 0;

  dmem_store_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .memread   (memread),
    .dataadr   (dataadr),
    .writedata (writedata),
    .readdata  (readdata),
    .stall     (stall),
    .pending   (pending),
    .drain_wr  (drain_wr),
    .drain_adr (drain_adr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  // Expected load data: youngest buffered match, else shadow RAM.
  task automatic lookup(input logic [5:0] i, output logic [31:0] val, output bit known);
    val   = mmem[i];
    known = mknown[i];
    for (int k = 0; k < sbq.size(); k++) begin
      if (sbq[k].idx == i) begin
        val   = sbq[k].data;
        known = 1'b1;
      end
    end
  endtask

  // One clock cycle: drive inputs, check combinational outputs, predict the
  // edge, then check registered outputs just after it.
  task automatic applyStimulus(input logic rst, input logic mw, input logic mr,
                               input logic [31:0] adr, input logic [31:0] wd);
    logic [31:0] expRd;
    bit          known;
    bit          doEnq, doDrn;
    entry_t      e;
    reset     = rst;
    memwrite  = mw;
    memread   = mr;
    dataadr   = adr;
    writedata = wd;
    #1;
    checkOutput("stall", {31'b0, stall}, {31'b0, !rst && mw && (sbq.size() == DEPTH)});
    if (mr && !mw && !rst) begin
      lookup(adr[7:2], expRd, known);
      if (known) checkOutput($sformatf("readdata@%h", adr), readdata, expRd);
    end
    if (rst) begin
      sbq.delete();
      expDrain    = 1'b0;
      expDrainAdr = '0;
    end else begin
      doEnq = mw && (sbq.size() != DEPTH);
      doDrn = (sbq.size() != 0) && !mr;
      expDrain = doDrn;
      if (doDrn) begin
        e = sbq.pop_front();
        mmem[e.idx]   = e.data;
        mknown[e.idx] = 1'b1;
        expDrainAdr   = e.idx;
      end
      if (doEnq) sbq.push_back('{idx: adr[7:2], data: wd});
    end
    @(posedge clk);
    #1;
    checkOutput("pending",   {29'b0, pending},   32'(sbq.size()));
    checkOutput("drain_wr",  {31'b0, drain_wr},  {31'b0, expDrain});
    checkOutput("drain_adr", {26'b0, drain_adr}, {26'b0, expDrainAdr});
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mmem[i]   = '0;
      mknown[i] = 1'b0;
    end
    expDrain    = 1'b0;
    expDrainAdr = '0;
    @(posedge clk);
    #1;
    $display("[TB] reset");
    applyStimulus(1, 0, 0, 32'h0, 32'h0);
    applyStimulus(1, 1, 0, 32'h4, 32'h9);

    $display("[TB] single store then drain");
    applyStimulus(0, 1, 0, 32'h0C, 32'd16);
    applyStimulus(0, 0, 0, 32'h0, 32'h0);
    applyStimulus(0, 0, 1, 32'h0C, 32'h0);

    $display("[TB] fill buffer, stall on full, drain in order");
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, 32'(i * 4), 32'(i + 1));
    applyStimulus(0, 1, 1, 32'h10, 32'd5);
    applyStimulus(0, 0, 1, 32'h08, 32'h0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 32'(i * 4), 32'h0);

    $display("[TB] forwarding youngest, RAM fallback, aliasing");
    applyStimulus(0, 1, 1, 32'h0C, 32'd16);
    applyStimulus(0, 1, 1, 32'h0C, 32'd32);
    applyStimulus(0, 0, 1, 32'h0C, 32'h0);
    applyStimulus(0, 1, 0, 32'h50, 32'h55);
    applyStimulus(0, 0, 0, 32'h0, 32'h0);
    applyStimulus(0, 0, 0, 32'h0, 32'h0);
    applyStimulus(0, 0, 1, 32'h50, 32'h0);
    applyStimulus(0, 0, 1, 32'h1053, 32'h0);

    $display("[TB] pointer wrap-around");
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, (i % 2) == 0, 32'h20, 32'(i + 2));
    applyStimulus(0, 0, 1, 32'h20, 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 32'h0, 32'h0);
    applyStimulus(0, 0, 1, 32'h20, 32'h0);

    $display("[TB] reset discards buffered stores");
    applyStimulus(0, 1, 0, 32'h14, 32'hAA);
    applyStimulus(0, 0, 0, 32'h0, 32'h0);
    applyStimulus(0, 1, 1, 32'h14, 32'hBB);
    applyStimulus(0, 1, 1, 32'h18, 32'hCC);
    applyStimulus(0, 1, 1, 32'h1C, 32'hDD);
    applyStimulus(1, 1, 0, 32'h14, 32'hEE);
    applyStimulus(0, 0, 1, 32'h14, 32'h0);

    $display("[TB] reset while full with a store presented");
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, 32'h14, 32'(i + 100));
    applyStimulus(1, 1, 1, 32'h14, 32'h77);
    applyStimulus(0, 0, 1, 32'h14, 32'h0);
    applyStimulus(0, 0, 0, 32'h0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_store_buffer.md
Name: dmem_store_buffer

Overview:
Data-memory responder on the single-cycle core's store/load interface: `memwrite`, `dataadr`, `writedata`, plus `memread` and `readdata`.
- Stores are posted into a small in-order store buffer.
- The buffer drains to a word-addressed RAM on cycles with no load in progress.
- Loads see the youngest buffered store to the same word (forwarding).
- Asserts `stall` to the core when a store arrives while the buffer is full.
- Sits between the core's data port and the testbench/top-level memory observer.

Parameters:
- `AW`, 6, RAM word-address width; RAM holds 2^AW 32-bit words.
- `DEPTH`, 4, store-buffer entries; power of two, >= 2.
- `CW`, 3, width of `pending`; equals log2(DEPTH)+1.

Ports:
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high.
- `memwrite` input 1: store request this cycle.
- `memread` input 1: load in progress this cycle.
- `dataadr` input 32: byte address; word index = `dataadr[AW+1:2]`.
- `writedata` input 32: store data.
- `readdata` output 32: load data, combinational.
- `stall` output 1: store not accepted this cycle; core must hold its store.
- `pending` output CW: number of valid buffer entries.
- `drain_wr` output 1: registered pulse; a buffer entry was written to RAM on the last edge.
- `drain_adr` output AW: registered; word index of the last drained entry.

Behaviour:
- Reset (sync, active-high):
  - Buffer emptied, head/tail pointers = 0, `pending` = 0.
  - `drain_wr` = 0, `drain_adr` = 0; `stall` = 0 while `reset` is high.
  - RAM contents are not cleared.
  - Entries pending at reset are discarded and never reach RAM.
- Address handling:
  - `dataadr[1:0]` ignored (word access only).
  - Bits above AW+1 ignored; addresses alias modulo 2^AW words.
- Enqueue, on the rising edge when `memwrite` && `pending` != DEPTH:
  - {word index, `writedata`} written at tail; tail += 1 mod DEPTH.
- Stall:
  - `stall` = `memwrite` && (`pending` == DEPTH), combinational, evaluated on the current count.
  - A full buffer never accepts a store, even if it drains that same edge; the core retries next cycle.
- Drain, on the rising edge when `pending` != 0 && !`memread`:
  - Head entry written to `RAM[idx]`; head += 1 mod DEPTH.
  - `drain_wr` <= 1 and `drain_adr` <= idx; otherwise `drain_wr` <= 0.
- Count update:
  - Enqueue and drain on the same edge: `pending` unchanged.
  - Enqueue only: `pending` += 1.
  - Drain only: `pending` -= 1.
  - Order strictly FIFO; RAM receives stores in program order.
- Load path (combinational):
  - `readdata` = data of the youngest valid entry whose index matches `dataadr[AW+1:2]`; otherwise `RAM[index]`.
  - Youngest means nearest to tail, with correct wrap-around.
  - A store presented in the same cycle is not forwarded; the single-cycle core never loads and stores together.
  - When `memread` = 0, `readdata` still reflects the lookup; the value is don't-care to the core.
- `memread` && `memwrite` both high: no drain; enqueue per the normal rule.
- Pointers wrap modulo DEPTH. `pending` never exceeds DEPTH and never underflows.
- `memwrite` when `reset` = 1: ignored.

Test Plan:
- Store 16 to 0x0C (`memread` = 0) → `pending` = 1 after the edge. Next edge: `drain_wr` = 1, `drain_adr` = 3, `pending` = 0, RAM[3] = 16.
- `memread` held 1 while storing 1,2,3,4 to 0x00,0x04,0x08,0x0C → `pending` = 4. A 5th store (0x10, 5) gives `stall` = 1 and `pending` stays 4. Release `memread` → four drains in order to indices 0,1,2,3.
- With `memread` = 1, store 16 then 32 to 0x0C, then load 0x0C → `readdata` = 32 (forwarded). Load 0x50 (empty RAM index 20, preloaded 0x55) → `readdata` = 0x55.
- Wrap-around: 6 store/drain cycles with alternating `memread` push head/tail past DEPTH → forwarding picks the youngest entry. Final RAM matches program order: last write to 0x20 = 7 gives RAM[8] = 7.
- Simultaneous enqueue + drain at `pending` = 2 → `pending` remains 2, `drain_wr` = 1.
- Reset with `pending` = 3, RAM[5] preloaded 0xAA and a buffered store to 0x14 → after reset `pending` = 0, `drain_wr` = 0, and RAM[5] is still 0xAA (store discarded).
